// File: rtl/lsu_sequencer.sv
// Bit-serial load/store sequencer.
// Feeds the effective address and the store data into the serialiser one bit
// per cycle, runs the word-wide memory handshake, and returns load results one
// bit per cycle, LSB first. Misaligned accesses finish with a fault before any
// memory request is raised. Unacknowledged requests can time out.
module lsu_sequencer #(
    parameter int ADDR_BITS   = 12,
    parameter int DATA_BITS   = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  func,
    input  logic        addr_bit_in,
    input  logic        rs2_bit_in,
    output logic [2:0]  ser_func,
    output logic        ser_mode,
    output logic [4:0]  ser_bit_pos,
    output logic        ser_data_in_bit,
    output logic [31:0] ser_data_in_bus,
    input  logic        ser_data_out_bit,
    input  logic [31:0] ser_data_out_bus,
    input  logic [9:0]  ser_addr_bus,
    input  logic        ser_misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rd_bit_out,
    output logic        rd_bit_valid,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    // Operation codes; codes 5..7 are the stores.
    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    // Wait counter only needs to count up to ACK_TIMEOUT-1.
    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_CHECK  = 3'd2,
        S_MEM_RD = 3'd3,
        S_DATA   = 3'd4,
        S_MEM_WR = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [5:0]          cnt_reg;
    logic [WAIT_W-1:0]   wait_reg;
    logic [2:0]          func_reg;
    logic [1:0]          off_reg;
    logic                fault_reg;
    logic [9:0]          addr_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         rdata_reg;

    logic is_store;
    logic addr_last;
    logic data_last;
    logic timeout_hit;

    assign is_store    = (func_reg == OP_SB) || (func_reg == OP_SH) || (func_reg == OP_SW);
    assign addr_last   = (cnt_reg == 6'(ADDR_BITS - 1));
    assign data_last   = (cnt_reg == 6'(DATA_BITS - 1));
    // A disabled timeout never fires; the counter may then wrap freely.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_reg == WAIT_W'(ACK_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_ADDR;
            S_ADDR:   if (addr_last) state_next = S_CHECK;
            S_CHECK: begin
                if (ser_misaligned) state_next = S_DONE;
                else if (is_store)  state_next = S_DATA;
                else                state_next = S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ack)          state_next = S_DATA;
                else if (timeout_hit) state_next = S_DONE;
            end
            S_DATA:   if (data_last) state_next = is_store ? S_MEM_WR : S_DONE;
            S_MEM_WR: if (mem_ack || timeout_hit) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Phase counters, latched operation context and memory-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            wait_reg  <= '0;
            func_reg  <= '0;
            off_reg   <= '0;
            fault_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            // Bit counter restarts at every phase change.
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (state_reg == S_ADDR || state_reg == S_DATA) begin
                cnt_reg <= cnt_reg + 6'd1;
            end

            // Ack wait counter restarts on entry to either memory phase.
            if (state_next != state_reg) begin
                wait_reg <= '0;
            end else if (state_reg == S_MEM_RD || state_reg == S_MEM_WR) begin
                wait_reg <= wait_reg + 1'b1;
            end

            if (state_reg == S_IDLE && start) begin
                func_reg  <= func;
                fault_reg <= 1'b0;
            end

            // Byte offset comes from the two lowest address bits.
            if (state_reg == S_ADDR && cnt_reg == 6'd0) off_reg[0] <= addr_bit_in;
            if (state_reg == S_ADDR && cnt_reg == 6'd1) off_reg[1] <= addr_bit_in;

            if (state_reg == S_CHECK) begin
                if (ser_misaligned) fault_reg <= 1'b1;
                else                addr_reg  <= ser_addr_bus;
            end

            if ((state_reg == S_MEM_RD || state_reg == S_MEM_WR) && !mem_ack && timeout_hit) begin
                fault_reg <= 1'b1;
            end

            // Read word is held for the serialiser until the next load returns.
            if (state_reg == S_MEM_RD && mem_ack) rdata_reg <= mem_rdata;

            // Store word is captured as MEM_WR is entered.
            if (state_reg == S_DATA && data_last && is_store) wdata_reg <= ser_data_out_bus;
        end
    end

    assign ser_func        = func_reg;
    assign ser_data_in_bus = rdata_reg;
    assign mem_addr        = addr_reg;
    assign mem_wdata       = wdata_reg;

    // Per-state output decode.
    always_comb begin
        ser_mode        = 1'b0;
        ser_bit_pos     = 5'd0;
        ser_data_in_bit = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_wstrb       = 4'b0000;
        rd_bit_out      = 1'b0;
        rd_bit_valid    = 1'b0;
        busy            = (state_reg != S_IDLE);
        done            = 1'b0;
        fault           = 1'b0;
        case (state_reg)
            S_ADDR: begin
                ser_mode        = 1'b1;
                ser_bit_pos     = cnt_reg[4:0];
                ser_data_in_bit = addr_bit_in;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
            end
            S_DATA: begin
                ser_bit_pos = cnt_reg[4:0];
                if (is_store) begin
                    ser_data_in_bit = rs2_bit_in;
                end else begin
                    rd_bit_out   = ser_data_out_bit;
                    rd_bit_valid = 1'b1;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                case (func_reg)
                    OP_SB:   mem_wstrb = 4'b0001 << off_reg;
                    OP_SH:   mem_wstrb = 4'b0011 << off_reg;
                    OP_SW:   mem_wstrb = 4'b1111;
                    default: mem_wstrb = 4'b0000;
                endcase
            end
            S_DONE: begin
                done  = 1'b1;
                fault = fault_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Testbench for lsu_sequencer: models the serialiser, the upstream bit sources
// and a memory with programmable ack delay; expected outcomes are queued per
// operation and compared when done is seen.
module tb_lsu_sequencer;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4;
    localparam logic [2:0] SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func = 3'd0;
    logic        addr_bit_in;
    logic        rs2_bit_in;
    logic [2:0]  ser_func;
    logic        ser_mode;
    logic [4:0]  ser_bit_pos;
    logic        ser_data_in_bit;
    logic [31:0] ser_data_in_bus;
    logic        ser_data_out_bit;
    logic [31:0] ser_data_out_bus;
    logic [9:0]  ser_addr_bus;
    logic        ser_misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        rd_bit_out;
    logic        rd_bit_valid;
    logic        busy;
    logic        done;
    logic        fault;

    lsu_sequencer #(.ADDR_BITS(12), .DATA_BITS(32), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func),
        .addr_bit_in(addr_bit_in), .rs2_bit_in(rs2_bit_in),
        .ser_func(ser_func), .ser_mode(ser_mode), .ser_bit_pos(ser_bit_pos),
        .ser_data_in_bit(ser_data_in_bit), .ser_data_in_bus(ser_data_in_bus),
        .ser_data_out_bit(ser_data_out_bit), .ser_data_out_bus(ser_data_out_bus),
        .ser_addr_bus(ser_addr_bus), .ser_misaligned(ser_misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .rd_bit_out(rd_bit_out), .rd_bit_valid(rd_bit_valid),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // All narrow outputs packed together for reset checks.
    logic [30:0] misc_outs;
    assign misc_outs = {ser_func, ser_mode, ser_bit_pos, ser_data_in_bit, mem_req, mem_we,
                        mem_addr, mem_wstrb, rd_bit_out, rd_bit_valid, busy, done, fault};

    // Upstream bit sources: serial ALU address and register-file store data.
    logic [31:0] cur_addr = 32'd0;
    logic [31:0] cur_rs2 = 32'd0;
    assign addr_bit_in = cur_addr[ser_bit_pos];
    assign rs2_bit_in  = cur_rs2[ser_bit_pos];

    // Serialiser model.
    logic        clr = 1'b0;
    logic [11:0] m_addr;
    logic [31:0] m_store;
    logic [1:0]  m_off;
    logic        m_is_store;
    logic [31:0] m_cur;
    logic [31:0] m_word;
    logic [31:0] m_load;

    always @(posedge clk) begin
        if (clr) begin
            m_addr  <= '0;
            m_store <= '0;
        end else begin
            if (ser_mode) m_addr[ser_bit_pos] <= ser_data_in_bit;
            if (busy && !ser_mode && m_is_store) m_store <= m_store | m_cur;
        end
    end

    always_comb begin
        m_off      = m_addr[1:0];
        m_is_store = (ser_func >= SB);
        m_cur      = (busy && !ser_mode && m_is_store) ? ({31'd0, ser_data_in_bit} << ser_bit_pos) : 32'd0;
        ser_data_out_bus = (m_store | m_cur) << (8 * m_off);
        ser_addr_bus     = m_addr[11:2];
        ser_misaligned   = (((ser_func == LH) || (ser_func == LHU) || (ser_func == SH)) && m_addr[0]) ||
                           (((ser_func == LW) || (ser_func == SW)) && (m_addr[1:0] != 2'b00));
        m_word = ser_data_in_bus >> (8 * m_off);
        case (ser_func)
            LB:      m_load = {{24{m_word[7]}}, m_word[7:0]};
            LH:      m_load = {{16{m_word[15]}}, m_word[15:0]};
            LBU:     m_load = {24'd0, m_word[7:0]};
            LHU:     m_load = {16'd0, m_word[15:0]};
            default: m_load = m_word;
        endcase
        ser_data_out_bit = m_load[ser_bit_pos];
    end

    typedef struct {
        logic [2:0]  f;
        logic        fault;
        int          cycle;
        logic [9:0]  maddr;
        int          nreq;
        int          nwr;
        logic [31:0] result;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          req_base;
        int          wr_base;
        int          rd_base;
        int          start_cyc;
    } exp_t;

    exp_t exp_q[$];

    int          ack_delay = 0;
    int          req_run = 0;
    int          req_total = 0;
    int          wr_total = 0;
    int          rd_total = 0;
    int          done_total = 0;
    logic [9:0]  first_addr;
    logic        first_we;
    logic [9:0]  last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] rd_acc = '0;

    // Memory responder, load-bit collector and done scoreboard.
    always @(negedge clk) begin
        if (mem_req) begin
            if (req_run == 0) begin
                first_addr = mem_addr;
                first_we   = mem_we;
            end else begin
                chk("addr_stable", {22'd0, mem_addr}, {22'd0, first_addr});
                chk("we_stable", {31'd0, mem_we}, {31'd0, first_we});
            end
            if (!mem_we) chk("rd_wstrb", {28'd0, mem_wstrb}, 32'd0);
            req_total++;
            last_addr = mem_addr;
            if (mem_we) begin
                last_wdata = mem_wdata;
                last_wstrb = mem_wstrb;
            end
            mem_ack = (req_run == ack_delay);
            if (mem_ack && mem_we) wr_total++;
            req_run++;
        end else begin
            mem_ack = 1'b0;
            req_run = 0;
        end

        if (rd_bit_valid) begin
            rd_acc[ser_bit_pos] = rd_bit_out;
            rd_total++;
        end

        if (done) begin
            exp_t e;
            done_total++;
            chk("queue_nonempty", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fault", {31'd0, fault}, {31'd0, e.fault});
                chk("cycle", cyc - e.start_cyc, e.cycle);
                chk("nreq", req_total - e.req_base, e.nreq);
                chk("nwr", wr_total - e.wr_base, e.nwr);
                if (e.nreq > 0) chk("mem_addr", {22'd0, last_addr}, {22'd0, e.maddr});
                if (e.nwr > 0) begin
                    chk("wdata", last_wdata, e.wdata);
                    chk("wstrb", {28'd0, last_wstrb}, {28'd0, e.wstrb});
                end
                if (e.f <= LHU && !e.fault) begin
                    chk("rd_bits", rd_total - e.rd_base, 32);
                    chk("rd_result", rd_acc, e.result);
                end
                $display("op func=%0d fault=%0b cycle=%0d reqs=%0d addr=%h rd=%h wdata=%h wstrb=%b",
                         e.f, fault, cyc - e.start_cyc, req_total - e.req_base,
                         last_addr, rd_acc, last_wdata, last_wstrb);
            end
        end
    end

    // Issue one operation, queue its expected outcome and wait for done.
    task automatic run_op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int delay, input logic e_fault,
                          input int e_cycle, input logic [9:0] e_maddr, input int e_nreq,
                          input int e_nwr, input logic [31:0] e_result, input logic [31:0] e_wdata,
                          input logic [3:0] e_wstrb, input bit poke);
        exp_t e;
        int base;
        @(negedge clk);
        e.f = f; e.fault = e_fault; e.cycle = e_cycle; e.maddr = e_maddr;
        e.nreq = e_nreq; e.nwr = e_nwr; e.result = e_result; e.wdata = e_wdata;
        e.wstrb = e_wstrb; e.req_base = req_total; e.wr_base = wr_total;
        e.rd_base = rd_total; e.start_cyc = cyc;
        exp_q.push_back(e);
        base = done_total;
        clr = 1'b1; func = f; cur_addr = {20'd0, a}; cur_rs2 = rs2;
        mem_rdata = rdata; ack_delay = delay; start = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_total != base) break;
            if (poke && (i == 4 || i == 30)) begin
                start = 1'b1; func = SB;
            end else begin
                start = 1'b0; func = f;
            end
            @(negedge clk);
        end
        start = 1'b0; func = f;
        chk("op_done", done_total - base, 1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("reset_misc", {1'b0, misc_outs}, 32'd0);
        chk("reset_rbus", ser_data_in_bus, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_misc", {1'b0, misc_outs}, 32'd0);

        //     func a       rs2           rdata         dly flt cyc maddr  nreq nwr result        wdata         wstrb  poke
        run_op(LW,  12'h004, 32'h0,        32'h00008006, 0,  0,  47, 10'h001, 1, 0, 32'h00008006, 32'h0,        4'h0,  0);
        run_op(LB,  12'h001, 32'h0,        32'h0000FF00, 0,  0,  47, 10'h000, 1, 0, 32'hFFFFFFFF, 32'h0,        4'h0,  0);
        run_op(LBU, 12'h001, 32'h0,        32'h0000FF00, 0,  0,  47, 10'h000, 1, 0, 32'h000000FF, 32'h0,        4'h0,  0);
        run_op(SH,  12'h006, 32'h00007006, 32'h0,        0,  0,  47, 10'h001, 1, 1, 32'h0,        32'h70060000, 4'hC,  0);
        run_op(LW,  12'h002, 32'h0,        32'h0,        0,  1,  14, 10'h000, 0, 0, 32'h0,        32'h0,        4'h0,  0);
        run_op(SW,  12'h040, 32'hDEADBEEF, 32'h0,        -1, 1,  50, 10'h010, 4, 0, 32'h0,        32'h0,        4'h0,  0);
        run_op(SW,  12'h040, 32'hDEADBEEF, 32'h0,        2,  0,  49, 10'h010, 3, 1, 32'h0,        32'hDEADBEEF, 4'hF,  0);
        run_op(SB,  12'h003, 32'h000000A5, 32'h0,        0,  0,  47, 10'h000, 1, 1, 32'h0,        32'hA5000000, 4'h8,  0);
        run_op(LH,  12'h002, 32'h0,        32'h80010000, 1,  0,  48, 10'h000, 2, 0, 32'hFFFF8001, 32'h0,        4'h0,  0);
        run_op(LHU, 12'h003, 32'h0,        32'h0,        0,  1,  14, 10'h000, 0, 0, 32'h0,        32'h0,        4'h0,  0);

        // Abort a load in its DATA phase with reset; nothing may complete.
        @(negedge clk);
        base = done_total;
        clr = 1'b1; func = LW; cur_addr = 32'h00C; mem_rdata = 32'h12345678; ack_delay = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_rbus", ser_data_in_bus, 32'h12345678);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_misc", {1'b0, misc_outs}, 32'd0);
        chk("abort_rbus", ser_data_in_bus, 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_total - base, 0);

        // Normal load after the abort, with stray start pulses while busy.
        run_op(LW,  12'h008, 32'h0,        32'hCAFEF00D, 0,  0,  47, 10'h002, 1, 0, 32'hCAFEF00D, 32'h0,        4'h0,  1);
        repeat (3) @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
- Bit-serial load/store sequencer; sits directly upstream of Data_Serialiser and drives its mode, bitPos and data_in_bit.
- Streams the 12-bit effective address and the store data into the serialiser, then runs the word-wide memory handshake.
- On loads, returns result bits to the register file, one per cycle, LSB first.
- Checks misalignment before any memory access and aborts with a fault instead of touching memory.

Parameters:
- ADDR_BITS, 12: serial address length; ADDR phase lasts this many cycles.
- DATA_BITS, 32: serial data length; DATA phase lasts this many cycles.
- ACK_TIMEOUT, 255: max cycles mem_req waits for mem_ack before fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request from control unit; sampled only in IDLE.
- func  in  3  load/store op code (LB/LH/LW/LBU/LHU/SB/SH/SW defines); latched at start.
- addr_bit_in  in  1  effective-address bit from serial ALU, LSB first.
- rs2_bit_in  in  1  store-data bit from register file, LSB first.
- ser_func  out  3  latched func to serialiser.
- ser_mode  out  1  1 = address phase.
- ser_bit_pos  out  5  bit index to serialiser.
- ser_data_in_bit  out  1  muxed addr_bit_in/rs2_bit_in.
- ser_data_in_bus  out  32  held memory read word.
- ser_data_out_bit  in  1  load result bit.
- ser_data_out_bus  in  32  store word, already lane-shifted.
- ser_addr_bus  in  10  word address.
- ser_misaligned  in  1  alignment error.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  10  word address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte enables.
- mem_rdata  in  32  read data.
- mem_ack  in  1  completion.
- rd_bit_out  out  1  load result bit.
- rd_bit_valid  out  1  rd_bit_out valid.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- fault  out  1  qualifies done: misalign or timeout.

Behaviour:
- Reset (async): state IDLE, all counters 0, all outputs 0 (ser_data_in_bus = 0). Reset mid-operation drops mem_req immediately; no done or fault is emitted.
- States: IDLE, ADDR, CHECK, MEM_RD, DATA, MEM_WR, DONE.
- IDLE: start=1 latches func; next state ADDR. start in any other state is ignored.
- ADDR (ADDR_BITS cycles, cnt 0..ADDR_BITS-1):
  - ser_mode=1, ser_bit_pos=cnt[4:0], ser_data_in_bit=addr_bit_in.
  - addr bits 0 and 1 are captured into a 2-bit offset.
- CHECK (1 cycle): ser_mode=0.
  - ser_misaligned=1 → DONE with fault.
  - Else latch mem_addr=ser_addr_bus; go to MEM_RD for loads, DATA for stores.
- MEM_RD: mem_req=1, mem_we=0.
  - On mem_ack, latch mem_rdata into ser_data_in_bus (held until next load), then → DATA.
  - Ack in the first cycle is legal.
- DATA (DATA_BITS cycles, cnt 0..31): ser_bit_pos=cnt.
  - Load: rd_bit_out=ser_data_out_bit, rd_bit_valid=1.
  - Store: ser_data_in_bit=rs2_bit_in; rd_bit_valid=0.
  - Load → DONE; store → MEM_WR.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=ser_data_out_bus (sampled at entry), mem_wstrb per the strobe rule below. On mem_ack → DONE.
- Strobe rule, SB/SH/SW: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111. mem_wstrb=0 for loads.
- Timeout: wait counter resets on entry to MEM_RD/MEM_WR. If ACK_TIMEOUT≠0 and the counter reaches ACK_TIMEOUT without ack, drop mem_req → DONE with fault.
- DONE (1 cycle): done=1, fault per cause; → IDLE.
- Latency with same-cycle ack: done is high 47 cycles after the start edge, for both loads and stores. A fault from CHECK gives done at cycle 14.
- mem_addr and mem_we are stable for the entire time mem_req=1.

Test Plan:
- LW, addr 0x004, mem_rdata 0x00008006, ack first cycle → mem_addr 0x001, rd_bit_valid for 32 cycles, bits deserialise to 0x00008006, done at cycle 47, fault=0.
- LB, addr 0x001, mem_rdata 0x0000FF00 → result 0xFFFFFFFF. LBU with the same stimulus → 0x000000FF.
- SH, addr 0x006, rs2 0x00007006 → one write, mem_wdata 0x70060000, mem_wstrb 4'b1100, mem_addr 0x001.
- LW, addr 0x002 (misaligned) → mem_req never asserts, done+fault at cycle 14.
- SW, ack withheld, ACK_TIMEOUT=4 → mem_req high exactly 4 cycles, then done+fault. Repeat with ack on the 3rd wait cycle → fault=0.
- rst_n low during DATA of a load → all outputs 0 immediately. A subsequent LW runs with normal 47-cycle timing. start pulses while busy are ignored.
